// File: rtl/pifo_cmd_issue_buffer_pkg.sv
// pifo_cmd_pkg: command entry layout, field widths and idle output values
// shared by the issue buffer, its FIFO and the bus interface. The field widths
// are fixed here so that FIFO storage and port widths always agree.
package pifo_cmd_pkg;

  localparam int PTW           = 16;
  localparam int MTW           = 16;
  localparam int TREE_NUM      = 4;
  localparam int TREE_NUM_BITS = $clog2(TREE_NUM);
  localparam int DW            = MTW + PTW;

  // "priority" is a reserved word, so the priority field is called prio.
  typedef struct packed {
    logic                     pop;
    logic                     push;
    logic [PTW-1:0]           prio;
    logic [TREE_NUM_BITS-1:0] tree_id;
    logic [DW-1:0]            data;
  } cmd_entry_t;

  localparam logic [PTW-1:0]           IDLE_PRIORITY = '1;
  localparam logic [TREE_NUM_BITS-1:0] IDLE_TREE_ID  = '0;
  localparam logic [DW-1:0]            IDLE_DATA     = '1;

  localparam cmd_entry_t IDLE_ENTRY = '{pop: 1'b0, push: 1'b0, prio: IDLE_PRIORITY,
                                        tree_id: IDLE_TREE_ID, data: IDLE_DATA};

  // Build a queue entry; a pop-only command carries idle push fields.
  function automatic cmd_entry_t make_entry(input logic                     push,
                                            input logic                     pop,
                                            input logic [PTW-1:0]           prio,
                                            input logic [TREE_NUM_BITS-1:0] tree_id,
                                            input logic [DW-1:0]            data);
    cmd_entry_t e;
    e      = IDLE_ENTRY;
    e.pop  = pop;
    e.push = push;
    if (push) begin
      e.prio    = prio;
      e.tree_id = tree_id;
      e.data    = data;
    end
    return e;
  endfunction

endpackage

// File: rtl/pifo_cmd_issue_buffer_if.sv
// pifo_cmd_issue_buffer_if: trace-reader commands in, tree operations and
// status out. The master modport is the trace reader / tree side, the slave
// modport is the issue buffer.
interface pifo_cmd_issue_buffer_if #(
  parameter int DEPTH      = 8,
  parameter int DROP_CNT_W = 8
);
  import pifo_cmd_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     i_push;
  logic [PTW-1:0]           i_push_priority;
  logic [TREE_NUM_BITS-1:0] i_push_tree_id;
  logic [DW-1:0]            i_push_data;
  logic                     i_pop;
  logic                     i_finish;
  logic                     i_pifo_ready;

  logic                     o_push;
  logic [PTW-1:0]           o_push_priority;
  logic [TREE_NUM_BITS-1:0] o_push_tree_id;
  logic [DW-1:0]            o_push_data;
  logic                     o_pop;
  logic [CNT_W-1:0]         o_count;
  logic                     o_full;
  logic                     o_overflow;
  logic [DROP_CNT_W-1:0]    o_drop_count;
  logic                     o_done;

  modport master (
    output i_push, i_push_priority, i_push_tree_id, i_push_data, i_pop, i_finish, i_pifo_ready,
    input  o_push, o_push_priority, o_push_tree_id, o_push_data, o_pop,
    input  o_count, o_full, o_overflow, o_drop_count, o_done
  );

  modport slave (
    input  i_push, i_push_priority, i_push_tree_id, i_push_data, i_pop, i_finish, i_pifo_ready,
    output o_push, o_push_priority, o_push_tree_id, o_push_data, o_pop,
    output o_count, o_full, o_overflow, o_drop_count, o_done
  );
endinterface

// File: rtl/pifo_cmd_issue_buffer_fifo.sv
// cmd_fifo: synchronous FIFO of command entries. The head entry is read
// straight from storage; the issue buffer's output register provides the
// registered stage. A write while full is accepted when a read fires on the
// same edge.
module cmd_fifo
  import pifo_cmd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  cmd_entry_t                wr_data_i,
  input  logic                      rd_en_i,
  output cmd_entry_t                rd_data_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  cmd_entry_t       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_fire, rd_fire;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign rd_fire   = rd_en_i & ~empty_o;
  assign wr_fire   = wr_en_i & (~full_o | rd_fire);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage write; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Next pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_fire && !rd_fire)      count_d = count_q + 1'b1;
    else if (!wr_fire && rd_fire) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/pifo_cmd_issue_buffer.sv
// pifo_cmd_issue_buffer: queues trace-reader push/pop commands and issues them
// to the PIFO tree when the tree is ready and ISSUE_GAP cycles have passed
// since the previous issue. Tracks dropped commands and end-of-trace drain.
// Optional macro PIFO_CMD_BYPASS_EN: a command arriving at an empty FIFO while
// the issue condition holds goes straight to the output registers.
module pifo_cmd_issue_buffer
  import pifo_cmd_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ISSUE_GAP  = 1,
  parameter int DROP_CNT_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  pifo_cmd_issue_buffer_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  cmd_entry_t            cmd_in, fifo_head, issue_entry, out_q, out_d;
  logic                  cmd_present, issue_ok, issue, fifo_wr, fifo_rd, drop;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  overflow_q, overflow_d, fin_q, fin_d, done_q, done_d;

  assign cmd_present = bus.i_push | bus.i_pop;
  assign cmd_in      = make_entry(bus.i_push, bus.i_pop, bus.i_push_priority,
                                  bus.i_push_tree_id, bus.i_push_data);
  assign issue_ok    = bus.i_pifo_ready & (gap_q == '0);

`ifdef PIFO_CMD_BYPASS_EN
  assign issue       = issue_ok & (~fifo_empty | cmd_present);
  assign fifo_rd     = issue & ~fifo_empty;
  assign fifo_wr     = cmd_present & ~(issue & fifo_empty);
  assign issue_entry = fifo_empty ? cmd_in : fifo_head;
`else
  assign issue       = issue_ok & ~fifo_empty;
  assign fifo_rd     = issue;
  assign fifo_wr     = cmd_present;
  assign issue_entry = fifo_head;
`endif

  // A full FIFO only takes a new command if the head leaves on the same edge.
  assign drop = fifo_wr & fifo_full & ~fifo_rd;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (i_clk),
    .rst_ni    (i_arst_n),
    .wr_en_i   (fifo_wr),
    .wr_data_i (cmd_in),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Next state: output entry, issue spacing, drop accounting, finish/done.
  always_comb begin
    out_d      = issue ? issue_entry : IDLE_ENTRY;
    gap_d      = gap_q;
    if (issue)              gap_d = GAP_W'(ISSUE_GAP - 1);
    else if (gap_q != '0)   gap_d = gap_q - 1'b1;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    fin_d      = fin_q | bus.i_finish;
    done_d     = done_q | (fin_q & fifo_empty & ~cmd_present & ~issue);
  end

  // Control and output registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      out_q      <= IDLE_ENTRY;
      gap_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      fin_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      out_q      <= out_d;
      gap_q      <= gap_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      fin_q      <= fin_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_push          = out_q.push;
  assign bus.o_pop           = out_q.pop;
  assign bus.o_push_priority = out_q.prio;
  assign bus.o_push_tree_id  = out_q.tree_id;
  assign bus.o_push_data     = out_q.data;
  assign bus.o_count         = fifo_count;
  assign bus.o_full          = fifo_full;
  assign bus.o_overflow      = overflow_q;
  assign bus.o_drop_count    = drop_cnt_q;
  assign bus.o_done          = done_q;
endmodule

// File: doc/pifo_cmd_issue_buffer.md
Name: pifo_cmd_issue_buffer

Overview:
- Sits between the trace reader and the PIFO tree.
- Captures every push/pop command the trace reader emits. The trace reader has no backpressure, so commands are held in a small FIFO.
- Issues commands to the tree only when the tree is ready and a minimum spacing (ISSUE_GAP) has elapsed since the previous issue.
- Reports overflow and end-of-trace drain completion.

Parameters:
- PTW, 16, priority/payload width
- MTW, 16, metadata width
- TREE_NUM, 4, number of virtual trees; TREE_NUM_BITS = $clog2(TREE_NUM)
- DEPTH, 8, FIFO entries; power of two, at least 2; CNT_W = $clog2(DEPTH)+1
- ISSUE_GAP, 1, minimum cycles between successive issues; at least 1
- DROP_CNT_W, 8, width of the saturating drop counter

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  asynchronous active-low reset
- i_push  in  1  push command from trace reader
- i_push_priority  in  PTW  push priority
- i_push_tree_id  in  TREE_NUM_BITS  target tree
- i_push_data  in  MTW+PTW  push payload
- i_pop  in  1  pop command from trace reader
- i_finish  in  1  trace end marker
- i_pifo_ready  in  1  tree can accept an operation this cycle
- o_push  out  1  push issued (one-cycle pulse)
- o_push_priority  out  PTW  issued priority
- o_push_tree_id  out  TREE_NUM_BITS  issued tree id
- o_push_data  out  MTW+PTW  issued payload
- o_pop  out  1  pop issued (one-cycle pulse)
- o_count  out  CNT_W  FIFO occupancy
- o_full  out  1  count == DEPTH
- o_overflow  out  1  sticky: a command was dropped
- o_drop_count  out  DROP_CNT_W  dropped commands, saturating at all-ones
- o_done  out  1  sticky: finish seen and all commands issued

Behaviour:
- Reset values:
  - o_push, o_pop, o_overflow, o_done = 0
  - o_push_priority = '1, o_push_data = '1, o_push_tree_id = '0
  - o_count, o_drop_count = 0
  - FIFO pointers cleared; gap counter = 0; finish latch = 0
  - Reset mid-operation discards all queued commands and drops any in-flight issue.
- Enqueue:
  - A command exists when i_push|i_pop. Entry = {pop, push, priority, tree_id, data}.
  - When i_push=0, the priority/tree_id/data fields are stored as '1 / '0 / '1.
  - Push+pop in the same cycle form one entry and are issued together.
- Issue condition (evaluated each cycle): FIFO not empty, i_pifo_ready=1, gap counter == 0.
  - On the issue edge the head entry is loaded into the output registers and the FIFO pops.
  - The gap counter loads ISSUE_GAP-1 and then decrements by 1 per cycle to 0.
  - With ISSUE_GAP=1, back-to-back issues are allowed every cycle.
- Non-issue cycle: o_push/o_pop = 0 and the data outputs return to idle values ('1 / '0 / '1).
- Latency: a command sampled at edge t appears on the outputs after edge t+1 at the earliest (registered FIFO head).
- Full/overflow:
  - Enqueue while full is accepted only if a dequeue occurs on the same edge; count is then unchanged.
  - Otherwise the command is dropped: o_overflow is set and o_drop_count increments, saturating.
  - Dropped commands are never issued.
- Empty:
  - No issue.
  - Simultaneous enqueue into an empty FIFO does not issue on the same edge, except under the optional feature.
- Pointers wrap modulo DEPTH.
- Ordering: commands are issued strictly in arrival order.
- i_finish is latched (sticky). o_done is set on the edge after all of the following hold in one cycle:
  - finish latched
  - FIFO empty
  - no command present on the inputs
  - no issue occurring
- o_done stays high until reset.
- i_pifo_ready low stalls issue indefinitely; the gap counter still decrements.

Optional Feature:
- Macro: PIFO_CMD_BYPASS_EN.
- Defined: if the FIFO is empty, a command is present, and the issue condition (ready, gap==0) holds, the command bypasses the FIFO and is loaded directly into the output registers at edge t. Latency is 1 edge; count is unchanged.
- Undefined: every command passes through the FIFO; minimum latency is 2 edges.
- Either way, ordering and the gap rules are identical.

Decomposition:
- Package pifo_cmd_pkg holds:
  - typedef struct cmd_entry_t {pop, push, priority, tree_id, data}
  - idle-value constants IDLE_PRIORITY='1, IDLE_TREE_ID='0, IDLE_DATA='1
- Sub-module cmd_fifo: generic synchronous FIFO of cmd_entry_t, DEPTH entries, with count/full/empty outputs and simultaneous read/write support when full.
- Top level holds the issue control, gap counter, drop counter, finish/done logic, and output registers.

Test Plan:
- Single push (priority 5, tree 2, data 0x1234) with ready=1, ISSUE_GAP=1 → o_push pulses with those values 2 edges later (1 with bypass); outputs then idle at '1/'0/'1.
- 4 back-to-back pushes, ISSUE_GAP=3, ready=1 → issues on cycles n, n+3, n+6, n+9, in order; o_count peaks at 3 (2 with bypass) and returns to 0.
- DEPTH=8, ready=0, 10 pushes → o_full after the 8th, o_overflow=1, o_drop_count=2; release ready → exactly 8 issues, in order.
- Push+pop in the same cycle (priority 7) → a single issue cycle with o_push=1 and o_pop=1.
- Full FIFO with ready=1 and a new command on the dequeue edge → command accepted, no drop, count stays 8.
- i_finish after 3 commands, ready toggling 1/0 → o_done rises one edge after the 3rd issue; assert reset mid-stream → all outputs return to reset values and queued commands are never issued.
